// File: rtl/pi1_rrarb_pkg.sv
// Shared PI1 op encodings, arbiter FSM states and width helpers for pi1_rrarb.
package pi1_rrarb_pkg;

  localparam logic [1:0] PINOOP = 2'b00;
  localparam logic [1:0] PIWROP = 2'b01;
  localparam logic [1:0] PIRDOP = 2'b10;
  localparam logic [1:0] PIRWOP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_RDATA = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // A zero-width counter is not legal, so unlimited bursts still get one bit.
  function automatic int cnt_bits(input int maxburst);
    return (maxburst == 0) ? 1 : clog2(maxburst + 1);
  endfunction

  function automatic int ptr_bits(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pi1_rrarb_pick.sv
// Combinational circular priority picker: first requester at or after ptr wins.
module pi1_rrarb_pick
  import pi1_rrarb_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pi1_rrarb.sv
// Round-robin arbiter sharing one PI1 slave port among several PI1 masters,
// one completion pulse per op and a burst cap on each grant.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no grant; pick next requester circularly from ptr
// ST_XFER  | granted master's op presented to slave, waiting for accept
// ST_RDATA | read accepted; slave sees PINOOP until read data returns
module pi1_rrarb
  import pi1_rrarb_pkg::*;
#(
  parameter  int MASTERCOUNT = 2,
  parameter  int ARCHBITSZ   = 32,
  parameter  int MAXBURST    = 8,
  localparam int SELBITSZ    = ARCHBITSZ / 8,
  localparam int ADDRBITSZ   = ARCHBITSZ - clog2(ARCHBITSZ / 8)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [2*MASTERCOUNT-1:0]        m_op_i,
  input  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_addr_i,
  input  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_i,
  input  logic [SELBITSZ*MASTERCOUNT-1:0]  m_sel_i,
  output logic [ARCHBITSZ-1:0]            m_data_o,
  output logic [MASTERCOUNT-1:0]          m_rdy_o,
  output logic [MASTERCOUNT-1:0]          gnt_o,
  output logic [1:0]                      s_op_o,
  output logic [ADDRBITSZ-1:0]            s_addr_o,
  output logic [ARCHBITSZ-1:0]            s_data_o,
  output logic [SELBITSZ-1:0]             s_sel_o,
  input  logic [ARCHBITSZ-1:0]            s_data_i,
  input  logic                            s_rdy_i
);

  localparam int PW = ptr_bits(MASTERCOUNT);
  localparam int CW = cnt_bits(MAXBURST);
  localparam logic [CW-1:0] CNT_LIM = CW'(MAXBURST);
  localparam logic [PW-1:0] PTR_LAST = PW'(MASTERCOUNT - 1);

  state_t                 state_q, state_d;
  logic [MASTERCOUNT-1:0] gnt_q, gnt_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;

  logic [MASTERCOUNT-1:0] req, pick;
  logic [PW-1:0]          g_idx, g_next;
  logic [1:0]             g_op;
  logic [ADDRBITSZ-1:0]   g_addr;
  logic [ARCHBITSZ-1:0]   g_data;
  logic [SELBITSZ-1:0]    g_sel;
  logic                   rel;
  logic                   end_wr, end_rd;

  always_comb begin
    req = '0;
    for (int i = 0; i < MASTERCOUNT; i++)
      req[i] = (m_op_i[2*i +: 2] != PINOOP);
  end

  pi1_rrarb_pick #(
    .N  (MASTERCOUNT),
    .PW (PW)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick)
  );

  // Grant is one-hot, so a plain select of the matching master is enough.
  always_comb begin
    g_op   = PINOOP;
    g_addr = '0;
    g_data = '0;
    g_sel  = '0;
    g_idx  = '0;
    for (int i = 0; i < MASTERCOUNT; i++) begin
      if (gnt_q[i]) begin
        g_op   = m_op_i[2*i +: 2];
        g_addr = m_addr_i[i*ADDRBITSZ +: ADDRBITSZ];
        g_data = m_data_i[i*ARCHBITSZ +: ARCHBITSZ];
        g_sel  = m_sel_i[i*SELBITSZ +: SELBITSZ];
        g_idx  = PW'(i);
      end
    end
  end

  assign g_next  = (g_idx == PTR_LAST) ? '0 : g_idx + PW'(1);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
  // With MAXBURST=0 the counter only saturates and never ends a burst.
  assign end_wr  = (MAXBURST != 0) && (cnt_inc == CNT_LIM);
  assign end_rd  = (MAXBURST != 0) && (cnt_q == CNT_LIM);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    rel      = 1'b0;
    m_rdy_o  = '0;
    s_op_o   = PINOOP;
    s_addr_o = g_addr;
    s_data_o = g_data;
    s_sel_o  = g_sel;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d   = pick;
          cnt_d   = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        s_op_o = g_op;
        if (g_op == PINOOP) begin
          rel = 1'b1;
        end else if (s_rdy_i) begin
          cnt_d = cnt_inc;
          if (g_op == PIWROP) begin
            m_rdy_o = gnt_q;
            rel     = end_wr;
          end else begin
            state_d = ST_RDATA;
          end
        end
      end
      ST_RDATA: begin
        if (s_rdy_i) begin
          m_rdy_o = gnt_q;
          if (end_rd) rel = 1'b1;
          else        state_d = ST_XFER;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    // Every handoff goes through IDLE, costing one bubble cycle.
    if (rel) begin
      state_d = ST_IDLE;
      gnt_d   = '0;
      ptr_d   = g_next;
    end
  end

  assign m_data_o = s_data_i;
  assign gnt_o    = gnt_q;

endmodule

// File: tb/tb_pi1_rrarb.sv
// Directed self-checking bench for pi1_rrarb: one DUT with MAXBURST=4, one with MAXBURST=0.
module tb_pi1_rrarb;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] WR  = 2'b01;
  localparam logic [1:0] RD  = 2'b10;

  logic clk_i = 1'b0;
  logic rst_i;

  logic [3:0]  a_op;
  logic [59:0] a_addr;
  logic [63:0] a_data;
  logic [7:0]  a_sel;
  logic [31:0] a_sdata;
  logic        a_srdy;
  logic [31:0] a_mdata;
  logic [1:0]  a_mrdy, a_gnt, a_sop;
  logic [29:0] a_saddr;
  logic [31:0] a_sdo;
  logic [3:0]  a_ssel;

  logic [3:0]  b_op;
  logic [59:0] b_addr;
  logic [63:0] b_data;
  logic [7:0]  b_sel;
  logic [31:0] b_sdata;
  logic        b_srdy;
  logic [31:0] b_mdata;
  logic [1:0]  b_mrdy, b_gnt, b_sop;
  logic [29:0] b_saddr;
  logic [31:0] b_sdo;
  logic [3:0]  b_ssel;

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_gnt [11];

  always #5 clk_i = ~clk_i;

  pi1_rrarb #(.MASTERCOUNT(2), .ARCHBITSZ(32), .MAXBURST(4)) u_dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .m_op_i   (a_op),
    .m_addr_i (a_addr),
    .m_data_i (a_data),
    .m_sel_i  (a_sel),
    .m_data_o (a_mdata),
    .m_rdy_o  (a_mrdy),
    .gnt_o    (a_gnt),
    .s_op_o   (a_sop),
    .s_addr_o (a_saddr),
    .s_data_o (a_sdo),
    .s_sel_o  (a_ssel),
    .s_data_i (a_sdata),
    .s_rdy_i  (a_srdy)
  );

  pi1_rrarb #(.MASTERCOUNT(2), .ARCHBITSZ(32), .MAXBURST(0)) u_dut_nb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .m_op_i   (b_op),
    .m_addr_i (b_addr),
    .m_data_i (b_data),
    .m_sel_i  (b_sel),
    .m_data_o (b_mdata),
    .m_rdy_o  (b_mrdy),
    .gnt_o    (b_gnt),
    .s_op_o   (b_sop),
    .s_addr_o (b_saddr),
    .s_data_o (b_sdo),
    .s_sel_o  (b_ssel),
    .s_data_i (b_sdata),
    .s_rdy_i  (b_srdy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};

    rst_i   = 1'b1;
    a_op    = '0;
    a_addr  = {30'h22, 30'h10};
    a_data  = {32'h1111_1111, 32'hA0A0_0000};
    a_sel   = {4'hC, 4'hF};
    a_sdata = '0;
    a_srdy  = 1'b0;
    b_op    = '0;
    b_addr  = {30'h5, 30'h40};
    b_data  = {32'h2222_2222, 32'h3333_3333};
    b_sel   = 8'hFF;
    b_sdata = '0;
    b_srdy  = 1'b0;
    #1 rst_i = 1'b0;

    // 1: reset held while m0 requests a write
    a_op = {NOP, WR};
    @(negedge clk_i); #1;
    chk("t1_rst_sop", a_sop, NOP);
    chk("t1_rst_rdy", a_mrdy, 2'b00);
    chk("t1_rst_gnt", a_gnt, 2'b00);
    @(negedge clk_i); rst_i = 1'b1; #1;
    chk("t1_idle_gnt", a_gnt, 2'b00);
    @(negedge clk_i); #1;
    chk("t1_gnt", a_gnt, 2'b01);
    chk("t1_sop", a_sop, WR);
    chk("t1_saddr", a_saddr, 30'h10);
    chk("t1_sdata", a_sdo, 32'hA0A0_0000);
    chk("t1_ssel", a_ssel, 4'hF);
    a_srdy = 1'b1; #1;
    chk("t1_wr_rdy", a_mrdy, 2'b01);
    @(negedge clk_i); a_op = {NOP, NOP}; a_srdy = 1'b0; #1;
    chk("t1_drop_gnt", a_gnt, 2'b01);
    chk("t1_drop_rdy", a_mrdy, 2'b00);
    chk("t1_drop_sop", a_sop, NOP);
    @(negedge clk_i); #1;
    chk("t1_rel_gnt", a_gnt, 2'b00);

    // 2: m0 read, slave accepts at t and returns data at t+3 (ptr is 1 here)
    a_op = {NOP, RD};
    @(negedge clk_i); #1;
    chk("t2_gnt", a_gnt, 2'b01);
    chk("t2_sop", a_sop, RD);
    chk("t2_saddr", a_saddr, 30'h10);
    a_srdy = 1'b1; #1;
    chk("t2_acc_rdy", a_mrdy, 2'b00);
    @(negedge clk_i); a_srdy = 1'b0; #1;
    chk("t2_t1_sop", a_sop, NOP);
    chk("t2_t1_rdy", a_mrdy, 2'b00);
    @(negedge clk_i); #1;
    chk("t2_t2_sop", a_sop, NOP);
    chk("t2_t2_rdy", a_mrdy, 2'b00);
    @(negedge clk_i); a_srdy = 1'b1; a_sdata = 32'hCAFE_F00D; #1;
    chk("t2_t3_sop", a_sop, NOP);
    chk("t2_t3_rdy", a_mrdy, 2'b01);
    chk("t2_t3_data", a_mdata, 32'hCAFE_F00D);
    @(negedge clk_i); a_srdy = 1'b0; a_op = {NOP, NOP}; #1;
    chk("t2_after_rdy", a_mrdy, 2'b00);
    chk("t2_after_gnt", a_gnt, 2'b01);
    @(negedge clk_i); #1;
    chk("t2_rel_gnt", a_gnt, 2'b00);

    // 3: both masters stream writes, burst limit 4, ptr back to 0
    rst_i = 1'b0; #1; rst_i = 1'b1;
    a_op = {WR, WR}; a_srdy = 1'b1; #1;
    chk("t3_idle_gnt", a_gnt, 2'b00);
    chk("t3_idle_rdy", a_mrdy, 2'b00);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk_i); #1;
      chk($sformatf("t3_gnt_%0d", i), a_gnt, exp_gnt[i]);
      chk($sformatf("t3_rdy_%0d", i), a_mrdy, exp_gnt[i]);
      if (exp_gnt[i] == 2'b01) chk($sformatf("t3_sdo_%0d", i), a_sdo, 32'hA0A0_0000);
      if (exp_gnt[i] == 2'b10) chk($sformatf("t3_sdo_%0d", i), a_sdo, 32'h1111_1111);
    end
    @(negedge clk_i); a_op = {NOP, NOP}; a_srdy = 1'b0;
    @(negedge clk_i);

    // 4: only m1 requests with ptr=0; its release wraps ptr to 0
    rst_i = 1'b0; #1; rst_i = 1'b1;
    a_op = {WR, NOP};
    @(negedge clk_i); #1;
    chk("t4_gnt", a_gnt, 2'b10);
    chk("t4_sop", a_sop, WR);
    chk("t4_saddr", a_saddr, 30'h22);
    chk("t4_ssel", a_ssel, 4'hC);
    chk("t4_rdy", a_mrdy, 2'b00);
    a_op = {NOP, NOP}; #1;
    chk("t4_drop_sop", a_sop, NOP);
    @(negedge clk_i); #1;
    chk("t4_rel_gnt", a_gnt, 2'b00);
    a_op = {WR, WR};
    @(negedge clk_i); #1;
    chk("t4_wrap_gnt", a_gnt, 2'b01);

    // 6: reset pulsed during RDATA abandons the read
    a_op = {NOP, RD}; a_srdy = 1'b1; #1;
    chk("t6_acc_rdy", a_mrdy, 2'b00);
    @(negedge clk_i); a_srdy = 1'b0; #1;
    chk("t6_rdata_sop", a_sop, NOP);
    chk("t6_rdata_gnt", a_gnt, 2'b01);
    rst_i = 1'b0; #1;
    chk("t6_rst_gnt", a_gnt, 2'b00);
    chk("t6_rst_sop", a_sop, NOP);
    chk("t6_rst_rdy", a_mrdy, 2'b00);
    a_srdy = 1'b1; #1;
    chk("t6_rst_srdy_rdy", a_mrdy, 2'b00);
    a_op = {NOP, NOP};
    @(negedge clk_i); rst_i = 1'b1; #1;
    chk("t6_post_rdy", a_mrdy, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i); #1;
      chk($sformatf("t6_idle_rdy_%0d", i), a_mrdy, 2'b00);
      chk($sformatf("t6_idle_gnt_%0d", i), a_gnt, 2'b00);
    end
    a_srdy = 1'b0;

    // 5: unlimited bursts, m0 streams 100 reads while m1 waits
    b_op = {WR, RD}; b_srdy = 1'b1;
    @(negedge clk_i); #1;
    for (int k = 0; k < 100; k++) begin
      chk($sformatf("t5_xfer_gnt_%0d", k), b_gnt, 2'b01);
      chk($sformatf("t5_xfer_rdy_%0d", k), b_mrdy, 2'b00);
      @(negedge clk_i); b_sdata = 32'h5000_0000 + 32'(k); #1;
      chk($sformatf("t5_rd_gnt_%0d", k), b_gnt, 2'b01);
      chk($sformatf("t5_rd_rdy_%0d", k), b_mrdy, 2'b01);
      chk($sformatf("t5_rd_data_%0d", k), b_mdata, 32'h5000_0000 + 32'(k));
      @(negedge clk_i); #1;
    end
    b_op = {WR, NOP}; #1;
    chk("t5_drop_gnt", b_gnt, 2'b01);
    chk("t5_drop_rdy", b_mrdy, 2'b00);
    @(negedge clk_i); #1;
    chk("t5_bubble_gnt", b_gnt, 2'b00);
    @(negedge clk_i); #1;
    chk("t5_m1_gnt", b_gnt, 2'b10);
    chk("t5_m1_rdy", b_mrdy, 2'b10);
    chk("t5_m1_sop", b_sop, WR);
    b_op = '0; b_srdy = 1'b0;
    @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
